// File: rtl/db_arbiter.sv
// rtl/db_arbiter.sv - two-master whole-transaction arbiter for the 32-bit data bus
// Optional watchdog: define DB_ARB_TIMEOUT_EN. `MEM_ACCESS_T defaults to a 3-bit access code.
`ifndef MEM_ACCESS_T
`define MEM_ACCESS_T logic [2:0]
`endif

module db_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         res_i,
  input  logic [31:0]  m0_addr_i,
  input  logic [31:0]  m0_dataOut_i,
  input  `MEM_ACCESS_T m0_accessType_i,
  output logic [31:0]  m0_dataIn_o,
  output logic         m0_ready_o,
  input  logic [31:0]  m1_addr_i,
  input  logic [31:0]  m1_dataOut_i,
  input  `MEM_ACCESS_T m1_accessType_i,
  output logic [31:0]  m1_dataIn_o,
  output logic         m1_ready_o,
  input  logic [31:0]  db_dataIn_i,
  input  logic         db_ready_i,
  output logic [31:0]  db_addr_o,
  output logic [31:0]  db_dataOut_o,
  output `MEM_ACCESS_T db_accessType_o,
  output logic [1:0]   arb_owner_o,
  output logic         arb_timeout_o
);

  typedef `MEM_ACCESS_T acc_t;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("db_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  acc_t        type_q, type_d;
  logic        req0, req1, pick1, granted, tmo;

  assign req0    = (m0_accessType_i != '0);
  assign req1    = (m1_accessType_i != '0);
  assign granted = (state_q == GRANT0) || (state_q == GRANT1);

  // On a tie, round-robin hands the bus to whoever did not finish last
  always_comb begin
    pick1 = 1'b0;
    if (req1 && !req0) begin
      pick1 = 1'b1;
    end else if (req1 && req0 && PRIORITY_MODE == 0) begin
      pick1 = (last_owner_q == 1'b0);
    end
  end

`ifdef DB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Counts GRANT cycles already spent waiting; IDLE leaves it at zero for the next grant
  always_comb begin
    cnt_d = '0;
    if (granted && !db_ready_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo = !res_i && granted && !db_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    type_d       = type_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = pick1 ? GRANT1 : GRANT0;
          addr_d  = pick1 ? m1_addr_i : m0_addr_i;
          wdata_d = pick1 ? m1_dataOut_i : m0_dataOut_i;
          type_d  = pick1 ? m1_accessType_i : m0_accessType_i;
        end
      end
      GRANT0, GRANT1: begin
        if (db_ready_i || tmo) begin
          state_d      = IDLE;
          last_owner_d = (state_q == GRANT1);
          type_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
        type_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      type_q       <= type_d;
    end
  end

  assign db_addr_o       = addr_q;
  assign db_dataOut_o    = wdata_q;
  assign db_accessType_o = type_q;
  assign arb_owner_o     = {state_q == GRANT1, state_q == GRANT0};
  assign arb_timeout_o   = tmo;

  // A reset cycle swallows any completion of the dropped transaction
  assign m0_ready_o  = !res_i && (state_q == GRANT0) && (db_ready_i || tmo);
  assign m1_ready_o  = !res_i && (state_q == GRANT1) && (db_ready_i || tmo);
  assign m0_dataIn_o = (tmo && state_q == GRANT0) ? 32'hDEADBEEF : db_dataIn_i;
  assign m1_dataIn_o = (tmo && state_q == GRANT1) ? 32'hDEADBEEF : db_dataIn_i;

endmodule
